// File: rtl/bit_serial_datapath.sv
// Bit-serial execution datapath: GPR and accumulator shift registers, a one-bit
// serial full adder, carry/sign flags and the next-bit counter fed back to the decoder.
module bit_serial_datapath #(
   parameter  int WIDTH = 8,
   localparam int CW    = $clog2(WIDTH)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_switches,
   input  logic [CW-1:0]    i_con_mux8,
   input  logic             i_con_mux,
   input  logic             i_con_muxalu,
   input  logic             i_con_gpr_shift,
   input  logic             i_con_gpr_sign,
   input  logic             i_con_acc_shift,
   input  logic             i_con_acc_sign,
   input  logic             i_con_sign_store,
   input  logic             i_con_blockcarry,
   input  logic             i_con_check_carry,
   output logic [CW-1:0]    o_data_count,
   output logic [WIDTH-1:0] o_gpr,
   output logic [WIDTH-1:0] o_acc,
   output logic             o_carry,
   output logic             o_sign
);

   logic [WIDTH-1:0] gpr, gpr_next;
   logic [WIDTH-1:0] acc, acc_next;
   logic             carry_reg;
   logic             carry_flag;
   logic             sign_flag;
   logic             cin, sum, cout, gpr_sin;

   // Serial adder works on the LSBs currently presented by both shift registers.
   assign cin     = i_con_blockcarry ? 1'b0 : carry_reg;
   assign sum     = gpr[0] ^ acc[0] ^ cin;
   assign cout    = (gpr[0] & acc[0]) | (cin & (gpr[0] ^ acc[0]));
   assign gpr_sin = i_con_mux ? i_switches[i_con_mux8] : gpr[0];

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs; no latch is inferred.
      gpr_next = gpr;
      acc_next = acc;
      if (i_con_gpr_shift) begin
         gpr_next = i_con_gpr_sign ? {gpr[WIDTH-1], gpr[WIDTH-1:1]}
                                   : {gpr_sin,      gpr[WIDTH-1:1]};
      end
      if (i_con_acc_shift) begin
         if (i_con_acc_sign)    acc_next = {acc[WIDTH-1], acc[WIDTH-1:1]};
         else if (i_con_muxalu) acc_next = {acc[0],       acc[WIDTH-1:1]};
         else                   acc_next = {sum,          acc[WIDTH-1:1]};
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         gpr        <= '0;
         acc        <= '0;
         carry_reg  <= 1'b0;
         carry_flag <= 1'b0;
         sign_flag  <= 1'b0;
      end else begin
         // NOTE: non-blocking updates make every right-hand side a pre-edge value, so
         // check_carry sees the old carry and the adder sees the old gpr[0]/acc[0].
         gpr <= gpr_next;
         acc <= acc_next;
         if (i_con_acc_shift && !i_con_muxalu) carry_reg  <= cout;
         if (i_con_check_carry)                carry_flag <= carry_reg;
         if (i_con_sign_store)                 sign_flag  <= gpr[WIDTH-1];
      end
   end

   assign o_data_count = i_con_mux8 + CW'(1);
   assign o_gpr        = gpr;
   assign o_acc        = acc;
   assign o_carry      = carry_flag;
   assign o_sign       = sign_flag;

endmodule

// File: tb/tb_bit_serial_datapath.sv
// Self-checking bench for bit_serial_datapath: table-driven add vectors with a
// scoreboard queue, plus hand-written reset, load, shift, count and hold sequences.
module tb_bit_serial_datapath;

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic [7:0] i_switches;
   logic [2:0] i_con_mux8;
   logic       i_con_mux, i_con_muxalu, i_con_gpr_shift, i_con_gpr_sign;
   logic       i_con_acc_shift, i_con_acc_sign, i_con_sign_store;
   logic       i_con_blockcarry, i_con_check_carry;
   logic [2:0] o_data_count;
   logic [7:0] o_gpr, o_acc;
   logic       o_carry, o_sign;

   bit_serial_datapath #(.WIDTH(8)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_switches(i_switches), .i_con_mux8(i_con_mux8),
      .i_con_mux(i_con_mux), .i_con_muxalu(i_con_muxalu),
      .i_con_gpr_shift(i_con_gpr_shift), .i_con_gpr_sign(i_con_gpr_sign),
      .i_con_acc_shift(i_con_acc_shift), .i_con_acc_sign(i_con_acc_sign),
      .i_con_sign_store(i_con_sign_store), .i_con_blockcarry(i_con_blockcarry),
      .i_con_check_carry(i_con_check_carry), .o_data_count(o_data_count),
      .o_gpr(o_gpr), .o_acc(o_acc), .o_carry(o_carry), .o_sign(o_sign)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [7:0] gpr;
      logic [7:0] acc;
      logic [7:0] exp_acc;
      logic       exp_carry;
   } add_vec_t;

   typedef struct {
      string      name;
      logic [7:0] gpr;
      logic [7:0] acc;
      logic       carry;
   } exp_t;

   add_vec_t add_tbl[6];
   exp_t     sb_q[$];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic clear_strobes();
      i_con_mux8 = 3'd0;  i_con_mux = 1'b0;  i_con_muxalu = 1'b0;
      i_con_gpr_shift = 1'b0;  i_con_gpr_sign = 1'b0;
      i_con_acc_shift = 1'b0;  i_con_acc_sign = 1'b0;
      i_con_sign_store = 1'b0; i_con_blockcarry = 1'b0; i_con_check_carry = 1'b0;
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      clear_strobes();
      i_rst = 1'b1;
      step();
      i_rst = 1'b0;
   endtask

   task automatic load_gpr(input logic [7:0] v);
      i_switches = v;
      for (int k = 0; k < 8; k++) begin
         clear_strobes();
         i_con_mux = 1'b1;  i_con_gpr_shift = 1'b1;  i_con_mux8 = 3'(k);
         step();
      end
      clear_strobes();
   endtask

   task automatic add8();
      for (int k = 0; k < 8; k++) begin
         clear_strobes();
         i_con_gpr_shift = 1'b1;  i_con_acc_shift = 1'b1;
         i_con_blockcarry = (k == 0);  i_con_mux8 = 3'(k);
         step();
      end
      clear_strobes();
   endtask

   task automatic check_carry_cycle(input logic block);
      clear_strobes();
      i_con_check_carry = 1'b1;  i_con_blockcarry = block;
      step();
      clear_strobes();
   endtask

   task automatic sb_compare();
      exp_t e;
      if (sb_q.size() == 0) begin
         n_checks++;
         $display("FAIL scoreboard_empty: got 0 entries expected 1");
         return;
      end
      e = sb_q.pop_front();
      check({e.name, "_gpr"},   o_gpr,          e.gpr);
      check({e.name, "_acc"},   o_acc,          e.acc);
      check({e.name, "_carry"}, 8'(o_carry),    8'(e.carry));
   endtask

   initial begin
      exp_t e;
      logic [2:0] exp_cnt;

      add_tbl[0] = '{8'h64, 8'h32, 8'h96, 1'b0};
      add_tbl[1] = '{8'hF0, 8'h20, 8'h10, 1'b1};
      add_tbl[2] = '{8'hFF, 8'h01, 8'h00, 1'b1};
      add_tbl[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
      add_tbl[4] = '{8'h55, 8'hAA, 8'hFF, 1'b0};
      add_tbl[5] = '{8'h80, 8'h80, 8'h00, 1'b1};

      i_switches = 8'h00;
      clear_strobes();
      i_rst = 1'b1;
      step();
      step();
      i_rst = 1'b0;

      // Preload gpr=A5, acc=3C, o_carry=1, o_sign=1; F0+4C also exercises a carried add.
      load_gpr(8'hF0);  add8();
      load_gpr(8'h4C);  add8();
      check_carry_cycle(1'b0);
      load_gpr(8'hA5);
      clear_strobes();  i_con_sign_store = 1'b1;  step();  clear_strobes();
      check("preload_gpr",   o_gpr,       8'hA5);
      check("preload_acc",   o_acc,       8'h3C);
      check("preload_carry", 8'(o_carry), 8'h01);
      check("preload_sign",  8'(o_sign),  8'h01);

      // Reset with every strobe active must still clear everything.
      i_rst = 1'b1;  i_switches = 8'hFF;  i_con_mux = 1'b1;
      i_con_gpr_shift = 1'b1;  i_con_acc_shift = 1'b1;
      i_con_check_carry = 1'b1;  i_con_sign_store = 1'b1;
      step();
      i_rst = 1'b0;  clear_strobes();
      check("reset_gpr",   o_gpr,       8'h00);
      check("reset_acc",   o_acc,       8'h00);
      check("reset_carry", 8'(o_carry), 8'h00);
      check("reset_sign",  8'(o_sign),  8'h00);

      // Load leaves the accumulator alone.
      load_gpr(8'h5A);  add8();
      load_gpr(8'h96);
      check("load_gpr", o_gpr, 8'h96);
      check("load_acc", o_acc, 8'h5A);

      // Table-driven adds: acc preloaded from gpr onto a cleared acc, then gpr+acc.
      for (int i = 0; i < 6; i++) begin
         do_reset();
         load_gpr(add_tbl[i].acc);  add8();
         load_gpr(add_tbl[i].gpr);
         e.name  = $sformatf("add%0d", i);
         e.gpr   = add_tbl[i].gpr;
         e.acc   = add_tbl[i].exp_acc;
         e.carry = add_tbl[i].exp_carry;
         sb_q.push_back(e);
         add8();
         check_carry_cycle(1'b0);
         sb_compare();
      end

      // Overflow then check_carry together with blockcarry.
      do_reset();
      load_gpr(8'h20);  add8();
      load_gpr(8'hF0);  add8();
      check_carry_cycle(1'b1);
      check("ovf_acc",   o_acc,       8'h10);
      check("ovf_carry", 8'(o_carry), 8'h01);

      // Hold: no shifts for 4 cycles with other strobes busy; pending carry not yet latched.
      do_reset();
      load_gpr(8'h80);  add8();
      load_gpr(8'h80);  add8();
      for (int k = 0; k < 4; k++) begin
         clear_strobes();
         i_switches = 8'hFF;  i_con_mux = 1'b1;  i_con_gpr_sign = 1'b1;
         i_con_acc_sign = 1'b1;  i_con_blockcarry = 1'b1;  i_con_mux8 = 3'(k);
         step();
      end
      clear_strobes();
      check("hold_gpr",       o_gpr,       8'h80);
      check("hold_acc",       o_acc,       8'h00);
      check("hold_flag",      8'(o_carry), 8'h00);
      check_carry_cycle(1'b0);
      check("hold_carry_reg", 8'(o_carry), 8'h01);

      // Sign store and arithmetic shift.
      do_reset();
      load_gpr(8'h84);
      clear_strobes();  i_con_sign_store = 1'b1;  step();  clear_strobes();
      check("sign_store", 8'(o_sign), 8'h01);
      for (int k = 0; k < 2; k++) begin
         clear_strobes();
         i_con_gpr_shift = 1'b1;  i_con_gpr_sign = 1'b1;  i_con_mux = 1'b1;
         i_switches = 8'h00;
         step();
      end
      clear_strobes();
      check("arith_gpr",  o_gpr,      8'hE1);
      check("sign_holds", 8'(o_sign), 8'h01);

      // Count sweep, including a sample taken while reset is asserted.
      for (int k = 0; k < 8; k++) begin
         i_con_mux8 = 3'(k);
         i_rst = (k == 3);
         #1;
         exp_cnt = (k == 7) ? 3'd0 : 3'(k + 1);
         check($sformatf("count_%0d", k), 8'(o_data_count), 8'(exp_cnt));
      end
      i_rst = 1'b0;
      clear_strobes();

      if (sb_q.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
